// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: groups the requester command bus and the bank
// status outputs of jk_bank_arbiter.
//   req  [NREQ]       level request per requester
//   op   [2*NREQ]     per-requester JK command, {J,K} at [2i+1:2i]
//   idx  [IDXW*NREQ]  per-requester target bit index
//   gnt  [NREQ]       one-hot grant pulse when a command is applied
//   busy              command being applied
//   err               out-of-range index pulse, aligned with gnt
//   q/qn [NBITS]      bank state and its complement
// master: requester side; slave: the arbiter.
interface jk_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NBITS = 6,
    parameter int IDXW  = 3
);
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    op;
    logic [IDXW*NREQ-1:0] idx;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic                 err;
    logic [NBITS-1:0]     q;
    logic [NBITS-1:0]     qn;

    modport master (
        output req, op, idx,
        input  gnt, busy, err, q, qn
    );

    modport slave (
        input  req, op, idx,
        output gnt, busy, err, q, qn
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: bank of NBITS JK storage bits shared by NREQ requesters.
// A round-robin arbiter picks one pending request in IDLE, captures its
// command, and the APPLY state commits it to the bank and grants.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  jk_bank_arbiter_if slave modport (req/op/idx in; gnt/busy/err/q/qn out)
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 6,
    parameter int IDXW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    jk_bank_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NB = NBITS;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] APPLY = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    w_c;
    logic [1:0]       op_c;
    logic [IDXW-1:0]  idx_c;
    logic [NBITS-1:0] q_r;
    logic [NBITS-1:0] q_next;
    logic [NREQ-1:0]  gnt_r;
    logic             busy_r;
    logic             err_r;
    logic             idx_ok;

    logic             win_vld;
    logic [PW-1:0]    win_c;
    logic [1:0]       win_op;
    logic [IDXW-1:0]  win_idx;

    // Round-robin scan as two ascending passes: indices at or above ptr
    // first, then the wrapped-around indices below ptr.
    always_comb begin
        win_vld = 1'b0;
        win_c   = '0;
        win_op  = '0;
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && bus.req[i] && (PW'(i) >= ptr)) begin
                win_vld = 1'b1;
                win_c   = PW'(i);
                win_op  = bus.op[2*i +: 2];
                win_idx = bus.idx[IDXW*i +: IDXW];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && bus.req[i] && (PW'(i) < ptr)) begin
                win_vld = 1'b1;
                win_c   = PW'(i);
                win_op  = bus.op[2*i +: 2];
                win_idx = bus.idx[IDXW*i +: IDXW];
            end
        end
    end

    assign idx_ok = (32'(idx_c) < NB);

    // Next bank value: only the addressed bit can change; an out-of-range
    // index matches no bit, leaving the bank untouched.
    always_comb begin
        q_next = q_r;
        for (int unsigned b = 0; b < NBITS; b++) begin
            if (32'(idx_c) == b) begin
                case (op_c)
                    2'b10:   q_next[b] = 1'b1;
                    2'b01:   q_next[b] = 1'b0;
                    2'b11:   q_next[b] = ~q_r[b];
                    default: q_next[b] = q_r[b];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            w_c    <= '0;
            op_c   <= '0;
            idx_c  <= '0;
            q_r    <= '0;
            gnt_r  <= '0;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            gnt_r <= '0;
            err_r <= 1'b0;
            if (state == IDLE) begin
                if (win_vld) begin
                    w_c    <= win_c;
                    op_c   <= win_op;
                    idx_c  <= win_idx;
                    state  <= APPLY;
                    busy_r <= 1'b1;
                end
            end else begin
                q_r    <= q_next;
                gnt_r  <= {{(NREQ-1){1'b0}}, 1'b1} << w_c;
                err_r  <= ~idx_ok;
                ptr    <= (w_c == LAST) ? '0 : w_c + 1'b1;
                state  <= IDLE;
                busy_r <= 1'b0;
            end
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.busy = busy_r;
    assign bus.err  = err_r;
    assign bus.q    = q_r;
    assign bus.qn   = ~q_r;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed self-checking bench for jk_bank_arbiter
// with NREQ=4, NBITS=6, IDXW=3 and hand-computed expectations.
module tb_jk_bank_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    jk_bank_arbiter_if #(.NREQ(4), .NBITS(6), .IDXW(3)) bus ();

    jk_bank_arbiter #(.NREQ(4), .NBITS(6), .IDXW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] jk_ops [5];
    logic [5:0] jk_q   [5];
    logic [3:0] rr_gnt [5];
    logic [5:0] rr_q   [5];

    initial begin
        total = 0;
        bad   = 0;
        jk_ops = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
        jk_q   = '{6'h05, 6'h05, 6'h04, 6'h05, 6'h04};
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_q   = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h0E};

        rst     = 1'b1;
        bus.req = '0;
        bus.op  = '0;
        bus.idx = '0;

        // Reset state
        #12;
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_qn", 32'(bus.qn), 32'h3F);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        tick();
        rst = 1'b0;

        // Single request: requester 0 sets bit 2; req dropped during APPLY
        bus.req = 4'b0001;
        bus.op  = 8'b0000_0010;
        bus.idx = 12'h002;
        tick();
        chk("t1_busy", 32'(bus.busy), 32'h1);
        chk("t1_gnt_early", 32'(bus.gnt), 32'h0);
        chk("t1_q_early", 32'(bus.q), 32'h00);
        bus.req = '0;
        tick();
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        chk("t1_q", 32'(bus.q), 32'h04);
        chk("t1_qn", 32'(bus.qn), 32'h3B);
        chk("t1_busy_off", 32'(bus.busy), 32'h0);
        chk("t1_err", 32'(bus.err), 32'h0);
        tick();
        chk("t1_gnt_off", 32'(bus.gnt), 32'h0);
        chk("t1_busy_idle", 32'(bus.busy), 32'h0);

        // JK truth table on bit 0 via requester 1 (bit 2 remains set)
        for (int k = 0; k < 5; k++) begin
            bus.req = 4'b0010;
            bus.op  = 8'(jk_ops[k]) << 2;
            bus.idx = 12'h000;
            tick();
            bus.req = '0;
            tick();
            chk("t2_gnt", 32'(bus.gnt), 32'h2);
            chk("t2_q", 32'(bus.q), 32'(jk_q[k]));
        end

        // Fresh reset, then round-robin with all requests held
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("t3_q_reset", 32'(bus.q), 32'h00);
        bus.req = 4'b1111;
        bus.op  = 8'hFF;
        bus.idx = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_gnt_gap", 32'(bus.gnt), 32'h0);
            chk("t3_busy", 32'(bus.busy), 32'h1);
            tick();
            chk("t3_gnt", 32'(bus.gnt), 32'(rr_gnt[k]));
            chk("t3_q", 32'(bus.q), 32'(rr_q[k]));
        end
        bus.req = '0;
        bus.op  = '0;
        tick();

        // Grant to requester 1 (hold) so ptr becomes 2
        bus.req = 4'b0010;
        bus.idx = '0;
        tick();
        bus.req = '0;
        tick();
        chk("t4_pre_gnt", 32'(bus.gnt), 32'h2);
        chk("t4_pre_q", 32'(bus.q), 32'h0E);

        // req=1001 with ptr=2: 3 first, then wraps to 0
        bus.req = 4'b1001;
        bus.op  = {2'b10, 2'b00, 2'b00, 2'b10};
        bus.idx = {3'd4, 3'd0, 3'd0, 3'd5};
        tick();
        tick();
        chk("t4_gnt3", 32'(bus.gnt), 32'h8);
        chk("t4_q3", 32'(bus.q), 32'h1E);
        bus.req = 4'b0001;
        tick();
        tick();
        chk("t4_gnt0", 32'(bus.gnt), 32'h1);
        chk("t4_q0", 32'(bus.q), 32'h3E);
        bus.req = 4'b0010;
        bus.op  = 8'b0000_0100;
        bus.idx = 12'b000_000_001_000;
        tick();
        tick();
        chk("t4_gnt1", 32'(bus.gnt), 32'h2);
        chk("t4_q1", 32'(bus.q), 32'h3C);

        // Out-of-range index: q holds, gnt and err pulse together
        bus.req = 4'b0100;
        bus.op  = 8'b0010_0000;
        bus.idx = 12'h1C0;
        tick();
        bus.req = '0;
        tick();
        chk("t5_gnt", 32'(bus.gnt), 32'h4);
        chk("t5_err", 32'(bus.err), 32'h1);
        chk("t5_q", 32'(bus.q), 32'h3C);
        tick();
        chk("t5_err_off", 32'(bus.err), 32'h0);
        chk("t5_gnt_off", 32'(bus.gnt), 32'h0);

        // Reset during APPLY: immediate clear, command dropped
        bus.req = 4'b0001;
        bus.op  = 8'h02;
        bus.idx = 12'h000;
        tick();
        chk("t6_busy", 32'(bus.busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_q", 32'(bus.q), 32'h00);
        chk("t6_qn", 32'(bus.qn), 32'h3F);
        chk("t6_gnt", 32'(bus.gnt), 32'h0);
        chk("t6_busy_off", 32'(bus.busy), 32'h0);
        bus.req = '0;
        tick();
        rst = 1'b0;
        chk("t6_gnt_hold", 32'(bus.gnt), 32'h0);
        chk("t6_q_hold", 32'(bus.q), 32'h00);

        // ptr back at 0: scan 0,1,2 reaches 2 before 3
        bus.req = 4'b1100;
        bus.op  = 8'h30;
        bus.idx = 12'h040;
        tick();
        chk("t6_busy2", 32'(bus.busy), 32'h1);
        bus.req = '0;
        tick();
        chk("t6_gnt2", 32'(bus.gnt), 32'h4);
        chk("t6_q2", 32'(bus.q), 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
